// File: rtl/music_score_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : music_score_sequencer
//  Purpose  : Walks a note table in score memory from a programmable start
//             address. Each note is timed from its duration field using a
//             beat tick. Supports pause/resume, abort, restart and looped
//             playback with a saturating loop counter.
//  Revision : 1.0 - initial release
// ============================================================================
module music_score_sequencer #(
    parameter int AddressBits = 5,
    parameter int DataLength  = 4,
    parameter int TimeBits    = 4,
    parameter int LoopBits    = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Stop,
    input  logic                   Pause,
    input  logic                   LoopEnable,
    input  logic                   BeatTick,
    input  logic [AddressBits-1:0] StartAddress,
    input  logic [DataLength-1:0]  KeyOutput,
    input  logic [TimeBits-1:0]    TimeOutput,
    output logic [AddressBits-1:0] CurrentAddress,
    output logic [DataLength-1:0]  NoteKey,
    output logic                   NoteActive,
    output logic                   NoteStart,
    output logic                   EndofScore,
    output logic [LoopBits-1:0]    LoopCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_PLAY   = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    // Highest memory address; playback never wraps past it.
    localparam logic [AddressBits-1:0] c_ADDR_LAST = '1;

    state_t                   state_q,  state_d;
    logic [AddressBits-1:0]   addr_q,   addr_d;
    logic [DataLength-1:0]    key_q,    key_d;
    logic [TimeBits-1:0]      dur_q,    dur_d;
    logic [TimeBits-1:0]      beat_q,   beat_d;
    logic [LoopBits-1:0]      loop_q,   loop_d;
    logic                     nstart_q, nstart_d;

    logic [TimeBits-1:0]      w_beat_inc;
    logic [LoopBits-1:0]      w_loop_inc;
    logic [AddressBits-1:0]   w_addr_inc;
    logic [TimeBits-1:0]      w_dur_fetch;

    assign w_beat_inc  = beat_q + TimeBits'(1);
    assign w_addr_inc  = addr_q + AddressBits'(1);
    // Loop counter sticks at all ones rather than wrapping.
    assign w_loop_inc  = (loop_q == '1) ? loop_q : loop_q + LoopBits'(1);
    // A zero duration would never end; treat it as a one-beat note.
    assign w_dur_fetch = (TimeOutput == '0) ? TimeBits'(1) : TimeOutput;

    // State and datapath registers; asynchronous reset to idle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            key_q    <= '0;
            dur_q    <= '0;
            beat_q   <= '0;
            loop_q   <= '0;
            nstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            key_q    <= key_d;
            dur_q    <= dur_d;
            beat_q   <= beat_d;
            loop_q   <= loop_d;
            nstart_q <= nstart_d;
        end
    end

    // Next-state logic: Stop beats Start, Start beats normal sequencing.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        key_d    = key_q;
        dur_d    = dur_q;
        beat_d   = beat_q;
        loop_d   = loop_q;
        nstart_d = 1'b0;

        if (Stop) begin
            // Idle reloads the start address anyway; doing it here keeps
            // the address valid on the very first idle cycle.
            state_d = S_IDLE;
            key_d   = '0;
            addr_d  = StartAddress;
        end else if (Start) begin
            // Fresh start from idle, or restart from any playing state.
            state_d = S_FETCH;
            addr_d  = StartAddress;
            loop_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = StartAddress;
                end

                S_FETCH: begin
                    if (KeyOutput == '0) begin
                        // End marker. Looping back to the marker's own
                        // address would spin forever on an empty score.
                        if (LoopEnable && (addr_q != StartAddress)) begin
                            addr_d = StartAddress;
                            loop_d = w_loop_inc;
                        end else begin
                            state_d = S_IDLE;
                            key_d   = '0;
                        end
                    end else begin
                        key_d    = KeyOutput;
                        dur_d    = w_dur_fetch;
                        beat_d   = '0;
                        nstart_d = 1'b1;
                        state_d  = S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (Pause) begin
                        // A tick arriving with Pause is dropped.
                        state_d = S_PAUSED;
                    end else if (BeatTick) begin
                        if (w_beat_inc == dur_q) begin
                            if (addr_q != c_ADDR_LAST) begin
                                addr_d  = w_addr_inc;
                                state_d = S_FETCH;
                            end else if (LoopEnable) begin
                                // Last memory word acts as an end marker.
                                addr_d  = StartAddress;
                                loop_d  = w_loop_inc;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_IDLE;
                                key_d   = '0;
                            end
                        end else begin
                            beat_d = w_beat_inc;
                        end
                    end
                end

                S_PAUSED: begin
                    if (!Pause) begin
                        state_d = S_PLAY;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    key_d   = '0;
                end
            endcase
        end
    end

    assign CurrentAddress = addr_q;
    assign NoteKey        = key_q;
    assign NoteActive     = (state_q == S_PLAY) || (state_q == S_PAUSED);
    assign NoteStart      = nstart_q;
    assign EndofScore     = (state_q == S_IDLE);
    assign LoopCount      = loop_q;

endmodule
`default_nettype wire

// File: tb/tb_music_score_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_music_score_sequencer
//  Purpose  : Directed self-checking bench for music_score_sequencer with a
//             small asynchronous-read score memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_music_score_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic       Pause = 1'b0;
    logic       LoopEnable = 1'b0;
    logic       BeatTick = 1'b0;
    logic [4:0] StartAddress = 5'd2;
    logic [3:0] KeyOutput;
    logic [3:0] TimeOutput;
    logic [4:0] CurrentAddress;
    logic [3:0] NoteKey;
    logic       NoteActive;
    logic       NoteStart;
    logic       EndofScore;
    logic [7:0] LoopCount;

    logic [3:0] mem_key  [0:31];
    logic [3:0] mem_time [0:31];

    int checks = 0;
    int failures = 0;

    assign KeyOutput  = mem_key[CurrentAddress];
    assign TimeOutput = mem_time[CurrentAddress];

    always #5 Clock = ~Clock;

    music_score_sequencer #(
        .AddressBits (5),
        .DataLength  (4),
        .TimeBits    (4),
        .LoopBits    (8)
    ) u_dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .Stop           (Stop),
        .Pause          (Pause),
        .LoopEnable     (LoopEnable),
        .BeatTick       (BeatTick),
        .StartAddress   (StartAddress),
        .KeyOutput      (KeyOutput),
        .TimeOutput     (TimeOutput),
        .CurrentAddress (CurrentAddress),
        .NoteKey        (NoteKey),
        .NoteActive     (NoteActive),
        .NoteStart      (NoteStart),
        .EndofScore     (EndofScore),
        .LoopCount      (LoopCount)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Three quiet cycles then one tick cycle: one beat every 4 cycles.
    task automatic do_tick();
        repeat (3) step();
        BeatTick = 1'b1;
        step();
        BeatTick = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_key[i]  = 4'd0;
            mem_time[i] = 4'd0;
        end
        mem_key[2] = 4'd5;  mem_time[2] = 4'd2;
        mem_key[3] = 4'd7;  mem_time[3] = 4'd1;
        mem_key[4] = 4'd0;  mem_time[4] = 4'd9;
        mem_key[6] = 4'd9;  mem_time[6] = 4'd3;
        mem_key[7] = 4'd11; mem_time[7] = 4'd0;
        mem_key[31] = 4'd4; mem_time[31] = 4'd1;

        // Reset values
        #2;
        check("rst_addr",  32'(CurrentAddress), 32'd0);
        check("rst_key",   32'(NoteKey), 32'd0);
        check("rst_active", 32'(NoteActive), 32'd0);
        check("rst_nstart", 32'(NoteStart), 32'd0);
        check("rst_eos",   32'(EndofScore), 32'd1);
        check("rst_loop",  32'(LoopCount), 32'd0);
        Reset = 1'b0;
        step();
        check("idle_addr", 32'(CurrentAddress), 32'd2);

        // Plain playback: 5 (2 beats), 7 (1 beat), end marker
        pulse_start();
        check("t1_fetch_active", 32'(NoteActive), 32'd0);
        check("t1_fetch_eos", 32'(EndofScore), 32'd0);
        step();
        check("t1_n1_start", 32'(NoteStart), 32'd1);
        check("t1_n1_key", 32'(NoteKey), 32'd5);
        check("t1_n1_addr", 32'(CurrentAddress), 32'd2);
        step();
        check("t1_n1_pulse_end", 32'(NoteStart), 32'd0);
        do_tick();
        check("t1_n1_mid", 32'(NoteActive), 32'd1);
        do_tick();
        check("t1_gap_active", 32'(NoteActive), 32'd0);
        check("t1_gap_addr", 32'(CurrentAddress), 32'd3);
        step();
        check("t1_n2_start", 32'(NoteStart), 32'd1);
        check("t1_n2_key", 32'(NoteKey), 32'd7);
        do_tick();
        check("t1_end_addr", 32'(CurrentAddress), 32'd4);
        step();
        check("t1_eos", 32'(EndofScore), 32'd1);
        check("t1_key0", 32'(NoteKey), 32'd0);
        check("t1_loop", 32'(LoopCount), 32'd0);
        step();
        check("t1_idle_addr", 32'(CurrentAddress), 32'd2);

        // Looped playback, then Stop
        LoopEnable = 1'b1;
        pulse_start();
        step();
        check("t2_n1_key", 32'(NoteKey), 32'd5);
        do_tick();
        do_tick();
        step();
        check("t2_n2_key", 32'(NoteKey), 32'd7);
        do_tick();
        step();
        check("t2_loop_addr", 32'(CurrentAddress), 32'd2);
        check("t2_loop_cnt", 32'(LoopCount), 32'd1);
        check("t2_loop_eos", 32'(EndofScore), 32'd0);
        step();
        check("t2_n3_start", 32'(NoteStart), 32'd1);
        check("t2_n3_key", 32'(NoteKey), 32'd5);
        do_tick();
        do_tick();
        step();
        check("t2_n4_key", 32'(NoteKey), 32'd7);
        Stop = 1'b1;
        Start = 1'b1;
        step();
        Stop = 1'b0;
        Start = 1'b0;
        check("t2_stop_eos", 32'(EndofScore), 32'd1);
        check("t2_stop_key", 32'(NoteKey), 32'd0);
        check("t2_stop_active", 32'(NoteActive), 32'd0);

        // Empty score with looping enabled never loops
        mem_key[2] = 4'd0;
        pulse_start();
        check("t3_fetch_eos", 32'(EndofScore), 32'd0);
        check("t3_loop_clr", 32'(LoopCount), 32'd0);
        step();
        check("t3_idle", 32'(EndofScore), 32'd1);
        check("t3_loop", 32'(LoopCount), 32'd0);
        mem_key[2] = 4'd5;

        // Pause during a 3-beat note, then a zero-duration note
        LoopEnable = 1'b0;
        StartAddress = 5'd6;
        step();
        pulse_start();
        step();
        check("t4_key", 32'(NoteKey), 32'd9);
        do_tick();
        Pause = 1'b1;
        step();
        repeat (10) do_tick();
        check("t4_paused_key", 32'(NoteKey), 32'd9);
        check("t4_paused_active", 32'(NoteActive), 32'd1);
        check("t4_paused_addr", 32'(CurrentAddress), 32'd6);
        Pause = 1'b0;
        step();
        do_tick();
        check("t4_beat2_addr", 32'(CurrentAddress), 32'd6);
        check("t4_beat2_active", 32'(NoteActive), 32'd1);
        do_tick();
        check("t4_end_addr", 32'(CurrentAddress), 32'd7);
        check("t4_end_active", 32'(NoteActive), 32'd0);
        step();
        check("t4_n2_key", 32'(NoteKey), 32'd11);
        do_tick();
        check("t4_t0_addr", 32'(CurrentAddress), 32'd8);
        step();
        check("t4_idle", 32'(EndofScore), 32'd1);

        // Last memory address: no wrap, loop returns to 31
        StartAddress = 5'd31;
        step();
        pulse_start();
        step();
        check("t5_key", 32'(NoteKey), 32'd4);
        do_tick();
        check("t5_nowrap_eos", 32'(EndofScore), 32'd1);
        check("t5_nowrap_addr", 32'(CurrentAddress), 32'd31);
        LoopEnable = 1'b1;
        pulse_start();
        step();
        do_tick();
        check("t5_loop_addr", 32'(CurrentAddress), 32'd31);
        check("t5_loop_cnt", 32'(LoopCount), 32'd1);
        check("t5_loop_eos", 32'(EndofScore), 32'd0);
        step();
        check("t5_relatch", 32'(NoteStart), 32'd1);

        // Asynchronous reset mid-note, then Start held with Stop
        #3;
        Reset = 1'b1;
        #1;
        check("t6_rst_addr", 32'(CurrentAddress), 32'd0);
        check("t6_rst_key", 32'(NoteKey), 32'd0);
        check("t6_rst_active", 32'(NoteActive), 32'd0);
        check("t6_rst_eos", 32'(EndofScore), 32'd1);
        check("t6_rst_loop", 32'(LoopCount), 32'd0);
        Start = 1'b1;
        Stop = 1'b1;
        #1;
        Reset = 1'b0;
        step();
        check("t6_addr_load", 32'(CurrentAddress), 32'd31);
        check("t6_stop_wins", 32'(EndofScore), 32'd1);
        step();
        check("t6_still_idle", 32'(EndofScore), 32'd1);
        Start = 1'b0;
        Stop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
